ram_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that turns the 64x8 dual-port RAM into a valid/ready stream buffer.
- Port 1 of the RAM is the write (push) port; port 2 is the read (pop) port.
- The RAM read is synchronous with 1-cycle latency. A 2-entry output buffer hides this latency, so a sustained 1 word/cycle in and out is possible.
- Sits between an upstream byte producer and downstream consumer; the RAM instance is a sibling, wired to the ram_* ports.

---
 rtl/ram_fifo_ctrl_pkg.sv | 7 +
 rtl/ram_fifo_ctrl_obuf2.sv | 38 +++
 rtl/ram_fifo_ctrl.sv | 80 ++++++++
 tb/tb_ram_fifo_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// ram_fifo_ctrl_pkg: geometry shared by the FIFO controller, its RAM and their benches
package ram_fifo_ctrl_pkg;
  localparam int FIFO_DW    = 8;
  localparam int FIFO_AW    = 6;
  localparam int FIFO_DEPTH = 2 ** FIFO_AW;
  localparam int FIFO_CW    = FIFO_AW + 2;
endpackage

// File: rtl/ram_fifo_ctrl_obuf2.sv
// fifo_obuf2: two-entry output skid buffer that absorbs the RAM read latency
module fifo_obuf2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_occ,
  output logic          o_valid
);
  logic [DW-1:0] r_d0;
  logic [DW-1:0] r_d1;
  logic [1:0]    r_occ;
  logic          w_slot;

  // new word lands in entry 1 only if entry 0 still holds something after this pop
  assign w_slot  = (r_occ == 2'd2) || (r_occ == 2'd1 && !i_pop);
  assign o_data  = r_d0;
  assign o_occ   = r_occ;
  assign o_valid = r_occ != 2'd0;

  // shift on pop, then append the captured word behind whatever remains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
      r_d0  <= '0;
      r_d1  <= '0;
    end else begin
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
      if (i_pop) r_d0 <= r_d1;
      if (i_push && !w_slot) r_d0 <= i_data;
      if (i_push && w_slot) r_d1 <= i_data;
    end
  end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready stream FIFO around a 64x8 dual-port RAM with 1-cycle read latency
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DW = FIFO_DW,
  parameter int AW = FIFO_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] ram_data1,
  output logic [AW-1:0] ram_adr1,
  output logic          ram_we1,
  output logic [DW-1:0] ram_data2,
  output logic [AW-1:0] ram_adr2,
  output logic          ram_we2,
  input  logic [DW-1:0] ram_q2,
  output logic [AW+1:0] count,
  output logic          empty
);
  localparam logic [AW:0] L_FULL = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_mem_cnt;
  logic          r_inflight;
  logic [1:0]    w_occ;
  logic          w_push;
  logic          w_pop;
  logic [2:0]    w_room;
  logic          w_rd_issue;

  assign in_ready   = r_mem_cnt != L_FULL;
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  // words the output buffer will hold after this edge, before any new read
  assign w_room     = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_rd_issue = (r_mem_cnt != '0) && (w_room < 3'd2);

  assign ram_data1 = in_data;
  assign ram_adr1  = r_wr_ptr;
  assign ram_we1   = w_push && rst_n;
  assign ram_data2 = '0;
  assign ram_adr2  = r_rd_ptr;
  assign ram_we2   = 1'b0;

  assign count = (AW+2)'(r_mem_cnt) + (AW+2)'(r_inflight) + (AW+2)'(w_occ);
  assign empty = count == '0;

  // pointers and RAM occupancy; a word written this edge is readable from the next cycle on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + AW'(w_push);
      r_rd_ptr   <= r_rd_ptr + AW'(w_rd_issue);
      r_mem_cnt  <= r_mem_cnt + (AW+1)'(w_push) - (AW+1)'(w_rd_issue);
      r_inflight <= w_rd_issue;
    end
  end

  fifo_obuf2 #(.DW(DW)) u_obuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  (ram_q2),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_occ   (w_occ),
    .o_valid (out_valid)
  );
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed checks of ram_fifo_ctrl with a behavioural 64x8 dual-port RAM
module tb_ram_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ram_data1;
  logic [5:0] ram_adr1;
  logic       ram_we1;
  logic [7:0] ram_data2;
  logic [5:0] ram_adr2;
  logic       ram_we2;
  logic [7:0] ram_q2;
  logic [7:0] count;
  logic       empty;
  logic [7:0] mem [64];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ram_data1 (ram_data1),
    .ram_adr1  (ram_adr1),
    .ram_we1   (ram_we1),
    .ram_data2 (ram_data2),
    .ram_adr2  (ram_adr2),
    .ram_we2   (ram_we2),
    .ram_q2    (ram_q2),
    .count     (count),
    .empty     (empty)
  );

  // sibling RAM: synchronous write on port 1, registered read on port 2
  always @(posedge clk) begin
    if (ram_we1) mem[ram_adr1] <= ram_data1;
    ram_q2 <= mem[ram_adr2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int acc, exp, gaps, sent, rcv, first, last, wraps, got;
    bit held;
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h77;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_we1_gated", ram_we1, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    @(posedge clk); #1;
    in_data = 8'h33;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("single_we1", ram_we1, 1);
    chk("single_adr1", ram_adr1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("single_adr2", ram_adr2, 0);
    chk("single_adr1_next", ram_adr1, 1);
    chk("single_count_e", count, 1);
    chk("single_nv_e", out_valid, 0);
    @(posedge clk); #2;
    chk("single_nv_e1", out_valid, 0);
    chk("single_count_e1", count, 1);
    @(posedge clk); #2;
    chk("single_valid_e2", out_valid, 1);
    chk("single_data_e2", out_data, 8'h33);
    @(posedge clk); #2;
    chk("single_empty_e3", empty, 1);
    chk("single_nv_e3", out_valid, 0);

    out_ready = 1'b0;
    acc = 0;
    held = 1'b0;
    for (int c = 0; c < 80; c++) begin
      in_data = 8'(acc);
      in_valid = 1'b1;
      #1;
      if (in_ready) acc++;
      else if (!held) begin
        chk("full_no_write", ram_we1, 0);
        held = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    chk("full_accepted", acc, 66);
    chk("full_count", count, 66);
    chk("full_in_ready", in_ready, 0);
    chk("full_valid", out_valid, 1);
    chk("full_head", out_data, 8'h00);

    out_ready = 1'b1;
    exp = 0;
    gaps = 0;
    #1;
    for (int c = 0; c < 100 && exp < 66; c++) begin
      if (out_valid) begin
        chk("drain_data", out_data, exp);
        exp++;
      end else gaps++;
      @(posedge clk); #2;
      if (c == 0) chk("drain_in_ready_back", in_ready, 1);
    end
    chk("drain_words", exp, 66);
    chk("drain_gaps", gaps, 0);
    chk("drain_nv", out_valid, 0);
    chk("drain_empty", empty, 1);

    sent = 0;
    rcv = 0;
    first = -1;
    last = -1;
    wraps = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 300 && rcv < 200; c++) begin
      in_valid = sent < 200;
      in_data = 8'(sent);
      #1;
      if (ram_we1 && ram_adr1 == 6'd63) wraps++;
      if (in_valid && in_ready) sent++;
      if (out_valid) begin
        chk("stream_data", out_data, rcv);
        if (rcv == 0) first = c;
        last = c;
        rcv++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    chk("stream_rcv", rcv, 200);
    chk("stream_no_bubbles", last - first, 199);
    chk("stream_wraps", wraps, 3);
    chk("stream_empty", empty, 1);

    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 200 && count != 8'd10; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_data = 8'h50 + 8'(acc);
      #1;
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("pre_reset_count", count, 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_nv", out_valid, 0);
    chk("async_empty", empty, 1);
    chk("async_data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_data = 8'hA0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'hA1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      #1;
      if (out_valid) begin
        chk("post_reset_data", out_data, got == 0 ? 8'hA0 : 8'hA1);
        got++;
      end
      @(posedge clk); #1;
    end
    chk("post_reset_words", got, 2);
    #1;
    chk("post_reset_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
